// File: rtl/rs.sv
// ALU-path reservation station: holds dispatched instructions until both operands
// resolve (via dispatch or CDB snoop), then issues the lowest-index ready entry.
module rs #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4,
    parameter int ROB_ID_W = 4,
    parameter int OPNUM_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                dsp_en,
    input  logic [OPNUM_W-1:0]  dsp_opnum,
    input  logic [31:0]         dsp_V1,
    input  logic [31:0]         dsp_V2,
    input  logic                dsp_Q1_busy,
    input  logic                dsp_Q2_busy,
    input  logic [ROB_ID_W-1:0] dsp_Q1,
    input  logic [ROB_ID_W-1:0] dsp_Q2,
    input  logic [31:0]         dsp_imm,
    input  logic [31:0]         dsp_pc,
    input  logic [ROB_ID_W-1:0] dsp_rob_id,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]         alu_cdb_data,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]         lsb_cdb_data,
    output logic                full,
    output logic                ex_valid,
    output logic [OPNUM_W-1:0]  ex_opnum,
    output logic [31:0]         ex_V1,
    output logic [31:0]         ex_V2,
    output logic [31:0]         ex_imm,
    output logic [31:0]         ex_pc,
    output logic [ROB_ID_W-1:0] ex_rob_id
);
    localparam int CNT_W = RS_IDX_W + 1;

    typedef struct packed {
        logic                busy;
        logic [OPNUM_W-1:0]  opnum;
        logic [31:0]         v1;
        logic [31:0]         v2;
        logic                q1_busy;
        logic                q2_busy;
        logic [ROB_ID_W-1:0] q1;
        logic [ROB_ID_W-1:0] q2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [ROB_ID_W-1:0] rob_id;
    } entry_t;

    typedef struct packed {
        logic [OPNUM_W-1:0]  opnum;
        logic [31:0]         v1;
        logic [31:0]         v2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [ROB_ID_W-1:0] rob_id;
    } issue_t;

    entry_t [RS_SIZE-1:0] ent_q, ent_d;
    issue_t               ex_q, ex_d;
    logic                 ex_valid_q, ex_valid_d;

    logic                 free_found, rdy_found;
    logic [RS_IDX_W-1:0]  free_idx, rdy_idx;
    logic [CNT_W-1:0]     free_cnt;

    // Returns {still_pending, value}; ALU and LSB never carry the same live tag.
    function automatic logic [32:0] snoop(input logic qb, input logic [ROB_ID_W-1:0] q,
                                          input logic [31:0] v);
        snoop = {qb, v};
        if (qb && alu_cdb_valid && alu_cdb_rob_id == q)
            snoop = {1'b0, alu_cdb_data};
        else if (qb && lsb_cdb_valid && lsb_cdb_rob_id == q)
            snoop = {1'b0, lsb_cdb_data};
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!ent_q[i].busy) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = RS_IDX_W'(i);
                end
            end
            if (ent_q[i].busy && !ent_q[i].q1_busy && !ent_q[i].q2_busy && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = RS_IDX_W'(i);
            end
        end
    end

    always_comb begin
        logic [32:0] r1, r2;
        ent_d      = ent_q;
        ex_d       = ex_q;
        ex_valid_d = 1'b0;
        r1         = '0;
        r2         = '0;
        if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].busy) begin
                        r1 = snoop(ent_q[i].q1_busy, ent_q[i].q1, ent_q[i].v1);
                        r2 = snoop(ent_q[i].q2_busy, ent_q[i].q2, ent_q[i].v2);
                        {ent_d[i].q1_busy, ent_d[i].v1} = r1;
                        {ent_d[i].q2_busy, ent_d[i].v2} = r2;
                    end
                end
                // Issue uses pre-edge operands: a ready entry has nothing left to snoop.
                if (rdy_found) begin
                    ex_valid_d            = 1'b1;
                    ex_d.opnum            = ent_q[rdy_idx].opnum;
                    ex_d.v1               = ent_q[rdy_idx].v1;
                    ex_d.v2               = ent_q[rdy_idx].v2;
                    ex_d.imm              = ent_q[rdy_idx].imm;
                    ex_d.pc               = ent_q[rdy_idx].pc;
                    ex_d.rob_id           = ent_q[rdy_idx].rob_id;
                    ent_d[rdy_idx].busy   = 1'b0;
                end
                if (dsp_en && free_found) begin
                    r1 = snoop(dsp_Q1_busy, dsp_Q1, dsp_V1);
                    r2 = snoop(dsp_Q2_busy, dsp_Q2, dsp_V2);
                    ent_d[free_idx].busy   = 1'b1;
                    ent_d[free_idx].opnum  = dsp_opnum;
                    {ent_d[free_idx].q1_busy, ent_d[free_idx].v1} = r1;
                    {ent_d[free_idx].q2_busy, ent_d[free_idx].v2} = r2;
                    ent_d[free_idx].q1     = dsp_Q1;
                    ent_d[free_idx].q2     = dsp_Q2;
                    ent_d[free_idx].imm    = dsp_imm;
                    ent_d[free_idx].pc     = dsp_pc;
                    ent_d[free_idx].rob_id = dsp_rob_id;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q      <= '0;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // One entry of slack covers the dispatcher's registered dsp_en.
    assign full      = (free_cnt <= CNT_W'(1));
    assign ex_valid  = ex_valid_q;
    assign ex_opnum  = ex_q.opnum;
    assign ex_V1     = ex_q.v1;
    assign ex_V2     = ex_q.v2;
    assign ex_imm    = ex_q.imm;
    assign ex_pc     = ex_q.pc;
    assign ex_rob_id = ex_q.rob_id;

endmodule

// File: tb/tb_rs.sv
// Directed bench for rs: reset, freeze, issue latency, CDB wakeup/forwarding,
// fill/full, drop-on-full, rollback and asynchronous reset.
module tb_rs;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
    logic        dsp_en = 1'b0, dsp_Q1_busy = 1'b0, dsp_Q2_busy = 1'b0;
    logic [5:0]  dsp_opnum = '0;
    logic [31:0] dsp_V1 = '0, dsp_V2 = '0, dsp_imm = '0, dsp_pc = '0;
    logic [3:0]  dsp_Q1 = '0, dsp_Q2 = '0, dsp_rob_id = '0;
    logic        alu_cdb_valid = 1'b0, lsb_cdb_valid = 1'b0;
    logic [3:0]  alu_cdb_rob_id = '0, lsb_cdb_rob_id = '0;
    logic [31:0] alu_cdb_data = '0, lsb_cdb_data = '0;
    logic        full, ex_valid;
    logic [5:0]  ex_opnum;
    logic [31:0] ex_V1, ex_V2, ex_imm, ex_pc;
    logic [3:0]  ex_rob_id;
    int          total = 0, bad = 0;

    rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .dsp_en(dsp_en), .dsp_opnum(dsp_opnum), .dsp_V1(dsp_V1), .dsp_V2(dsp_V2),
        .dsp_Q1_busy(dsp_Q1_busy), .dsp_Q2_busy(dsp_Q2_busy), .dsp_Q1(dsp_Q1), .dsp_Q2(dsp_Q2),
        .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob_id(dsp_rob_id),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_data(lsb_cdb_data),
        .full(full), .ex_valid(ex_valid), .ex_opnum(ex_opnum), .ex_V1(ex_V1), .ex_V2(ex_V2),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rob_id(ex_rob_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dsp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic q1b, input logic [3:0] q1, input logic q2b,
                           input logic [3:0] q2, input logic [31:0] pc, input logic [3:0] rob);
        dsp_en = 1'b1; dsp_opnum = op; dsp_V1 = v1; dsp_V2 = v2;
        dsp_Q1_busy = q1b; dsp_Q1 = q1; dsp_Q2_busy = q2b; dsp_Q2 = q2;
        dsp_pc = pc; dsp_imm = pc + 32'h1000; dsp_rob_id = rob;
    endtask

    task automatic alu(input logic [3:0] tag, input logic [31:0] d);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = tag; alu_cdb_data = d;
    endtask

    task automatic lsb(input logic [3:0] tag, input logic [31:0] d);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = tag; lsb_cdb_data = d;
    endtask

    task automatic idle();
        dsp_en = 1'b0; alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rob", 32'(ex_rob_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ready dispatch: issue one edge later, then ex_valid drops, data held
        set_dsp(6'd1, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h100, 4'd3);
        tick(); idle();
        chk("rd_e0_valid", 32'(ex_valid), 32'd0);
        tick();
        chk("rd_e1_valid", 32'(ex_valid), 32'd1);
        chk("rd_e1_v1", ex_V1, 32'd5);
        chk("rd_e1_v2", ex_V2, 32'd7);
        chk("rd_e1_pc", ex_pc, 32'h100);
        chk("rd_e1_imm", ex_imm, 32'h1100);
        chk("rd_e1_rob", 32'(ex_rob_id), 32'd3);
        chk("rd_e1_op", 32'(ex_opnum), 32'd1);
        tick();
        chk("rd_e2_valid", 32'(ex_valid), 32'd0);
        chk("rd_e2_hold", ex_V1, 32'd5);

        // Freeze: rdy low blocks issue and forces ex_valid low
        set_dsp(6'd2, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'h140, 4'd6);
        tick(); idle(); rdy = 1'b0;
        tick();
        chk("frz_valid0", 32'(ex_valid), 32'd0);
        tick();
        chk("frz_valid1", 32'(ex_valid), 32'd0);
        rdy = 1'b1;
        tick();
        chk("frz_issue", 32'(ex_valid), 32'd1);
        chk("frz_rob", 32'(ex_rob_id), 32'd6);
        rdy = 1'b0;
        tick();
        chk("frz_drop", 32'(ex_valid), 32'd0);
        rdy = 1'b1;
        tick();
        chk("frz_after", 32'(ex_valid), 32'd0);
        chk("frz_hold", 32'(ex_rob_id), 32'd6);

        // Wakeup: ALU and LSB resolve both operands of one entry in one cycle
        set_dsp(6'd3, 32'd0, 32'd0, 1'b1, 4'd5, 1'b1, 4'd6, 32'h200, 4'd4);
        tick(); idle();
        tick();
        chk("wk_wait", 32'(ex_valid), 32'd0);
        alu(4'd5, 32'hDEAD); lsb(4'd6, 32'h1);
        tick(); idle();
        chk("wk_nobypass", 32'(ex_valid), 32'd0);
        tick();
        chk("wk_valid", 32'(ex_valid), 32'd1);
        chk("wk_v1", ex_V1, 32'hDEAD);
        chk("wk_v2", ex_V2, 32'h1);
        chk("wk_rob", 32'(ex_rob_id), 32'd4);
        tick();
        chk("wk_done", 32'(ex_valid), 32'd0);

        // Same-cycle forward on dispatch
        set_dsp(6'd4, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 32'h240, 4'd7);
        lsb(4'd2, 32'd42);
        tick(); idle();
        chk("fw_e0", 32'(ex_valid), 32'd0);
        tick();
        chk("fw_valid", 32'(ex_valid), 32'd1);
        chk("fw_v1", ex_V1, 32'd9);
        chk("fw_v2", ex_V2, 32'd42);
        chk("fw_rob", 32'(ex_rob_id), 32'd7);

        // Fill: entries 3 and 7 wait on tag 13, the rest on tag 14
        for (int i = 0; i < 16; i++) begin
            set_dsp(6'd5, 32'(i), 32'd0, 1'b1, (i == 3 || i == 7) ? 4'd13 : 4'd14,
                    1'b0, 4'd0, 32'h400 + 32'(4 * i), 4'(i));
            tick();
            if (i == 13) chk("fill_14", 32'(full), 32'd0);
            if (i == 14) chk("fill_15", 32'(full), 32'd1);
            if (i == 15) chk("fill_16", 32'(full), 32'd1);
        end
        // Dispatch while full is dropped; had it landed it would issue next edge
        set_dsp(6'd6, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0, 32'h4F0, 4'd9);
        tick(); idle();
        alu(4'd13, 32'h77);
        tick(); idle();
        chk("drop_valid", 32'(ex_valid), 32'd0);
        chk("wk2_full", 32'(full), 32'd1);
        tick();
        chk("wk2_a_valid", 32'(ex_valid), 32'd1);
        chk("wk2_a_rob", 32'(ex_rob_id), 32'd3);
        chk("wk2_a_v1", ex_V1, 32'h77);
        chk("wk2_a_full", 32'(full), 32'd1);
        tick();
        chk("wk2_b_valid", 32'(ex_valid), 32'd1);
        chk("wk2_b_rob", 32'(ex_rob_id), 32'd7);
        chk("wk2_b_pc", ex_pc, 32'h41C);
        chk("wk2_b_full", 32'(full), 32'd0);
        tick();
        chk("wk2_done", 32'(ex_valid), 32'd0);

        // Rollback beats a ready entry and a concurrent dispatch
        set_dsp(6'd7, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 32'h300, 4'd1);
        tick();
        set_dsp(6'd8, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 32'h340, 4'd2);
        rollback = 1'b1;
        tick(); idle(); rollback = 1'b0;
        chk("rb_valid", 32'(ex_valid), 32'd0);
        chk("rb_full", 32'(full), 32'd0);
        tick();
        chk("rb_discard", 32'(ex_valid), 32'd0);
        alu(4'd14, 32'h99);
        tick(); idle();
        tick();
        chk("rb_flushed", 32'(ex_valid), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            set_dsp(6'd9, 32'd0, 32'd0, 1'b1, 4'd10, 1'b0, 4'd0, 32'h500, 4'(10 + i));
            tick();
        end
        set_dsp(6'd9, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 32'h510, 4'd13);
        tick(); idle();
        tick();
        chk("ar_pre_valid", 32'(ex_valid), 32'd1);
        chk("ar_pre_rob", 32'(ex_rob_id), 32'd13);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(ex_valid), 32'd0);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_pc", ex_pc, 32'd0);
        #2 rst = 1'b0;
        // Old entries waiting on tag 10 would win issue if they survived reset
        set_dsp(6'd10, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'h540, 4'd14);
        alu(4'd10, 32'h1);
        tick(); idle();
        tick();
        chk("ar_post_valid", 32'(ex_valid), 32'd1);
        chk("ar_post_rob", 32'(ex_rob_id), 32'd14);
        tick();
        chk("ar_post_done", 32'(ex_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs.md
Name: rs

Overview:
- Reservation station for the ALU path. Sits between the dispatcher and the ALU execute unit.
- Buffers decoded ALU instructions until both operands are resolved, snooping the ALU and LSB CDB broadcasts for operand values.
- Issues one ready instruction per cycle to the execute unit as opnum/V1/V2/imm/pc, plus the ROB tag for writeback.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_ID_W, 4, ROB tag width.
- OPNUM_W, 6, opcode-number width (matches `OPNUM_TYPE).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; low = freeze
- rollback  in  1  misprediction flush
- dsp_en  in  1  dispatch valid
- dsp_opnum  in  OPNUM_W  operation
- dsp_V1, dsp_V2  in  32  operand values
- dsp_Q1_busy, dsp_Q2_busy  in  1  operand still pending
- dsp_Q1, dsp_Q2  in  ROB_ID_W  producer ROB tags
- dsp_imm  in  32  immediate
- dsp_pc  in  32  instruction pc
- dsp_rob_id  in  ROB_ID_W  destination ROB tag
- alu_cdb_valid  in  1  ALU broadcast valid
- alu_cdb_rob_id  in  ROB_ID_W  ALU broadcast tag
- alu_cdb_data  in  32  ALU broadcast value
- lsb_cdb_valid  in  1  LSB broadcast valid
- lsb_cdb_rob_id  in  ROB_ID_W  LSB broadcast tag
- lsb_cdb_data  in  32  LSB broadcast value
- full  out  1  dispatcher must not dispatch next cycle
- ex_valid  out  1  issue valid
- ex_opnum  out  OPNUM_W  issued operation
- ex_V1, ex_V2  out  32  issued operands
- ex_imm  out  32  issued immediate
- ex_pc  out  32  issued pc
- ex_rob_id  out  ROB_ID_W  issued tag

Behaviour:
- Entry fields: busy, opnum, V1, V2, Q1_busy, Q2_busy, Q1, Q2, imm, pc, rob_id.
- Reset (async, rst=1): all busy=0; ex_valid=0; all ex_* data outputs 0; full=0.
- rdy=0: no state change; ex_valid held at 0 on the next edge.
- Priority at each posedge with rdy=1:
  - rollback=1: clear all busy, ex_valid<=0, ignore dispatch and issue.
  - Otherwise, dispatch, CDB update and issue all occur in the same edge.
- Dispatch:
  - When dsp_en=1, write the lowest-index free entry, computed from pre-edge state.
  - If dsp_Qx_busy and a CDB of the same cycle matches dsp_Qx, capture that data and store Qx_busy=0 (same-cycle forwarding).
  - Dispatch while no entry is free is a dispatcher error; the input is dropped and the bench flags it.
- CDB update: for each busy entry with Qx_busy=1 and a matching valid tag, Vx<=data and Qx_busy<=0. ALU and LSB may both broadcast in one cycle and update different operands of the same entry.
- Ready: busy && !Q1_busy && !Q2_busy, evaluated on pre-edge state. No wakeup-to-issue bypass in the same cycle.
- Issue:
  - Select the lowest-index ready entry. Drive it onto ex_* registered at the edge, with ex_valid<=1, and clear its busy.
  - With no ready entry: ex_valid<=0, ex_* hold previous values.
- Latency:
  - Dispatch with both operands resolved at edge N → issue at edge N+1 (ex_valid high in cycle N+1..N+2).
  - Operand resolved by CDB at edge N → earliest issue at edge N+1.
- Simultaneous dispatch and issue use different entries; the freed entry is not reusable until the next edge.
- full: combinational from pre-edge state; asserted when free entries ≤ 1. This gives one cycle of slack for the dispatcher's registered dsp_en.
- Tags compare on all ROB_ID_W bits; no wrap handling is needed (ROB guarantees unique live tags).

Test Plan:
- Reset mid-operation: 3 busy entries, assert rst asynchronously between edges → ex_valid=0, full=0 immediately. A subsequent dispatch lands in entry 0.
- Ready dispatch: opnum=ADD, V1=5, V2=7, pc=0x100, rob_id=3, both Q clear at edge 0 → edge 1: ex_valid=1, ex_V1=5, ex_V2=7, ex_pc=0x100, ex_rob_id=3; edge 2: ex_valid=0.
- Wakeup: dispatch with Q1_busy tag 5, then alu_cdb(5, 0xDEAD) two cycles later → issue one edge after the broadcast with ex_V1=0xDEAD. A simultaneous lsb_cdb(6, 0x1) on the same entry's Q2 also resolves.
- Same-cycle forward: dispatch Q2 tag 2 while lsb_cdb(2, 42) is valid → issue next edge with ex_V2=42.
- Fill: dispatch 15 blocked entries → full=1 with 1 free. After the 16th, one broadcast wakes entry 7 and entry 3 together → entry 3 issues first, entry 7 next cycle; full drops when free ≥ 2.
- Rollback with a ready entry and concurrent dsp_en → next cycle ex_valid=0, all entries free, the dispatched instruction is discarded.
